// File: rtl/k2red_unscale_if.sv
// Operand/result handshake bundle for k2red_unscale.
// Input side: in_valid/in_ready with X, KINV2, Q.
// Output side: out_valid/out_ready with C (and out_err when
// K2RED_UNSCALE_RANGE_CHECK_EN is defined).
interface k2red_unscale_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] X;
  logic [W-1:0] KINV2;
  logic [W-1:0] Q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] C;
`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
  logic         out_err;

  modport master (
    output in_valid, X, KINV2, Q, out_ready,
    input  in_ready, out_valid, C, out_err
  );

  modport slave (
    input  in_valid, X, KINV2, Q, out_ready,
    output in_ready, out_valid, C, out_err
  );
`else
  modport master (
    output in_valid, X, KINV2, Q, out_ready,
    input  in_ready, out_valid, C
  );

  modport slave (
    input  in_valid, X, KINV2, Q, out_ready,
    output in_ready, out_valid, C
  );
`endif
endinterface

// File: rtl/k2red_unscale.sv
// k2red_unscale: bit-serial interleaved modular multiplier computing
// C = X * KINV2 mod Q, removing the k^2 factor left by K2-RED reduction.
// One multiplier bit per cycle, MSB first; W RUN cycles per operation.
// Optional macro K2RED_UNSCALE_RANGE_CHECK_EN adds out_err, flagging
// X >= Q or KINV2 >= Q at accept (timing stays constant, C forced to 0).
module k2red_unscale #(
  parameter int W = 64
) (
  input  logic             clk,
  input  logic             rst,
  k2red_unscale_if.slave   bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic [W:0]    r;
  logic [W:0]    x;
  logic [W:0]    q;
  logic [W-1:0]  k;
  logic [CW-1:0] cnt;
  logic [W-1:0]  c;
  logic [W:0]    t_dbl;
  logic [W:0]    t_add;
  logic [W:0]    r_nx;
`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
  logic          err;
  logic          out_err;
`endif

  // Single conditional subtraction keeps a value below 2Q inside [0, Q).
  function automatic logic [W:0] cond_sub(input logic [W:0] t, input logic [W:0] m);
    return (t >= m) ? (t - m) : t;
  endfunction

  // One interleaved step: R <- (2R mod Q + bit*X) mod Q.
  always_comb begin
    t_dbl = cond_sub(r + r, q);
    t_add = k[W-1] ? (t_dbl + x) : t_dbl;
    r_nx  = cond_sub(t_add, q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic: accept in IDLE, W steps in RUN, hold result in DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = RUN;
      RUN:     if (cnt == '0)     state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // Operand capture, serial accumulation and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r   <= '0;
      x   <= '0;
      q   <= '0;
      k   <= '0;
      cnt <= '0;
      c   <= '0;
`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
      err     <= 1'b0;
      out_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x   <= {1'b0, bus.X};
            q   <= {1'b0, bus.Q};
            k   <= bus.KINV2;
            r   <= '0;
            cnt <= CW'(W - 1);
`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
            err <= (bus.X >= bus.Q) || (bus.KINV2 >= bus.Q);
`endif
          end
        end
        RUN: begin
          r   <= r_nx;
          k   <= {k[W-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
            c       <= err ? '0 : r_nx[W-1:0];
            out_err <= err;
`else
            c <= r_nx[W-1:0];
`endif
          end
        end
        DONE: begin
`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
          if (bus.out_ready) out_err <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // in_ready is held low while reset is asserted, even though state is IDLE.
  assign bus.in_ready  = (state == IDLE) && rst;
  assign bus.out_valid = (state == DONE);
  assign bus.C         = c;
`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
  assign bus.out_err   = out_err;
`endif

endmodule

// File: tb/tb_k2red_unscale.sv
// Testbench for k2red_unscale: scoreboard of expected results pushed at
// accept, popped when the DUT presents a result.
module tb_k2red_unscale;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  k2red_unscale_if #(.W(W)) bus();
  k2red_unscale #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] c;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, m};
    return p[W-1:0];
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.X = a;
    bus.KINV2 = b;
    bus.Q = m;
    for (int n = 0; ; n++) begin
      if (n > 200) begin
        $display("FAIL send: in_ready never rose");
        $fatal(1);
      end
      if (bus.in_ready === 1'b1) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
    e.err = (a >= m) || (b >= m);
`else
    e.err = 1'b0;
`endif
    e.c = e.err ? '0 : model(a, b, m);
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(output logic [W-1:0] c, output logic e, output int lat);
    for (int n = 0; ; n++) begin
      if (n > W + 50) begin
        $display("FAIL get_result: out_valid never rose");
        $fatal(1);
      end
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
    end
    lat = cyc - acc_cyc;
    c = bus.C;
`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
    e = bus.out_err;
`else
    e = 1'b0;
`endif
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.X = '0;
    bus.KINV2 = '0;
    bus.Q = W'(49);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.C !== '0) begin bad++; $display("FAIL reset_C: got %h want 0", bus.C); end
`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
`endif
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic;
    logic [W-1:0] c; logic e; int lat; exp_t x;
    send(W'(9), W'(11), W'(49));
    bus.Q = W'(64'hDEAD);
    bus.KINV2 = W'(3);
    get_result(c, e, lat);
    x = sb.pop_front();
    total++; if (c !== x.c) begin bad++; $display("FAIL basic_C: got %h want %h", c, x.c); end
    total++; if (c !== W'(1)) begin bad++; $display("FAIL basic_C_const: got %h want 1", c); end
    total++; if (lat !== W) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, W); end
  endtask

  task automatic test_wide;
    logic [W-1:0] c; logic e; int lat; exp_t x; logic [W-1:0] qw;
    qw = 64'hFFFFFFFF00000001;
    send(qw - 1, qw - 1, qw);
    get_result(c, e, lat);
    x = sb.pop_front();
    total++; if (c !== W'(1)) begin bad++; $display("FAIL wide_sq: got %h want 1", c); end
    total++; if (c !== x.c) begin bad++; $display("FAIL wide_sq_model: got %h want %h", c, x.c); end
    send(64'h123456789, W'(1), qw);
    get_result(c, e, lat);
    x = sb.pop_front();
    total++; if (c !== 64'h123456789) begin bad++; $display("FAIL wide_one: got %h want 123456789", c); end
    total++; if (lat !== W) begin bad++; $display("FAIL wide_latency: got %0d want %0d", lat, W); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] c; logic e; int lat; exp_t x;
    send(W'(48), W'(0), W'(49));
    get_result(c, e, lat);
    x = sb.pop_front();
    total++; if (c !== '0) begin bad++; $display("FAIL zero_k: got %h want 0", c); end
    total++; if (lat !== W) begin bad++; $display("FAIL zero_k_latency: got %0d want %0d", lat, W); end
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_out_valid: got %b want 0", bus.out_valid); end
    send(W'(20), W'(30), W'(49));
    get_result(c, e, lat);
    x = sb.pop_front();
    total++; if (c !== W'(12)) begin bad++; $display("FAIL b2b_C: got %h want c", c); end
    total++; if (c !== x.c) begin bad++; $display("FAIL b2b_model: got %h want %h", c, x.c); end
    send(W'(0), W'(37), W'(49));
    get_result(c, e, lat);
    x = sb.pop_front();
    total++; if (c !== x.c) begin bad++; $display("FAIL zero_x: got %h want %h", c, x.c); end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] c; logic e; int lat; exp_t x;
    bus.out_ready = 1'b0;
    send(W'(10), W'(5), W'(49));
    x = sb.pop_front();
    for (int n = 0; ; n++) begin
      if (n > W + 50) begin
        $display("FAIL bp_wait: out_valid never rose");
        $fatal(1);
      end
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
    end
    bus.in_valid = 1'b1;
    bus.X = W'(3);
    bus.KINV2 = W'(17);
    bus.Q = W'(49);
    for (int n = 0; n < 5; n++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", n, bus.out_valid); end
      total++; if (bus.C !== x.c) begin bad++; $display("FAIL bp_C[%0d]: got %h want %h", n, bus.C, x.c); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", n, bus.in_ready); end
      @(negedge clk);
    end
    total++; if (bus.C !== W'(1)) begin bad++; $display("FAIL bp_C_const: got %h want 1", bus.C); end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(W'(3), W'(17), W'(49));
    get_result(c, e, lat);
    x = sb.pop_front();
    total++; if (c !== W'(2)) begin bad++; $display("FAIL bp_next_C: got %h want 2", c); end
    total++; if (lat !== W) begin bad++; $display("FAIL bp_next_latency: got %0d want %0d", lat, W); end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] c; logic e; int lat; exp_t x;
    send(W'(9), W'(11), W'(49));
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.C !== '0) begin bad++; $display("FAIL midrst_C: got %h want 0", bus.C); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); end
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(W'(2), W'(25), W'(49));
    get_result(c, e, lat);
    x = sb.pop_front();
    total++; if (c !== W'(1)) begin bad++; $display("FAIL midrst_next_C: got %h want 1", c); end
    total++; if (lat !== W) begin bad++; $display("FAIL midrst_next_latency: got %0d want %0d", lat, W); end
  endtask

`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
  task automatic test_range_check;
    logic [W-1:0] c; logic e; int lat; exp_t x;
    send(W'(49), W'(11), W'(49));
    get_result(c, e, lat);
    x = sb.pop_front();
    total++; if (e !== 1'b1) begin bad++; $display("FAIL rc_err: got %b want 1", e); end
    total++; if (c !== '0) begin bad++; $display("FAIL rc_C: got %h want 0", c); end
    total++; if (lat !== W) begin bad++; $display("FAIL rc_latency: got %0d want %0d", lat, W); end
    send(W'(9), W'(11), W'(49));
    get_result(c, e, lat);
    x = sb.pop_front();
    total++; if (e !== x.err) begin bad++; $display("FAIL rc_ok_err: got %b want %b", e, x.err); end
    total++; if (c !== W'(1)) begin bad++; $display("FAIL rc_ok_C: got %h want 1", c); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
`ifdef K2RED_UNSCALE_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
